wb_master08: RTL and testbench
==============================

WB_MASTER08 -- requirements
Module: wb_master08

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of 2).
REQ-002 SHALL have parameter TMO, default 16, max bus cycles waited for ACK_I before abort.
REQ-003 SHALL have port CLK_I  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_I  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port CMD_VALID  in  1  host command present.
REQ-006 SHALL have port CMD_READY  out  1  FIFO not full.
REQ-007 SHALL have port CMD_OP  in  2  00 write, 01 read, 10 read-modify-write, 11 reserved.
REQ-008 SHALL have port CMD_ADR  in  4  target address.
REQ-009 SHALL have port CMD_DAT  in  8  write data (RMW: bits to set).
REQ-010 SHALL have port CMD_MSK  in  8  RMW mask; 1 = bit replaced by CMD_DAT.
REQ-011 SHALL have port RSP_VALID  out  1  one-cycle completion pulse.
REQ-012 SHALL have port RSP_DAT  out  8  completion data.
REQ-013 SHALL have port RSP_ERR  out  1  completion error flag, valid with RSP_VALID.
REQ-014 SHALL have port CYC_O  out  1  Wishbone cycle.
REQ-015 SHALL have port STB_O  out  1  Wishbone strobe.
REQ-016 SHALL have port WE_O  out  1  Wishbone write enable.
REQ-017 SHALL have port ADR_O  out  4  Wishbone address.
REQ-018 SHALL have port DAT_O  out  8  Wishbone write data.
REQ-019 SHALL have port DAT_I  in  8  Wishbone read data.
REQ-020 SHALL have port ACK_I  in  1  Wishbone acknowledge (may be combinational from STB_O).

Function
REQ-021 SHALL push {OP,ADR,DAT,MSK} into the FIFO on an edge where CMD_VALID & CMD_READY; CMD_READY = (count != DEPTH).
REQ-022 SHALL implement states IDLE, WR, RD, RMW_RD, RMW_WR, RSP.
REQ-023 SHALL in IDLE with FIFO non-empty pop the head into command registers on the next edge and go to WR/RD/RMW_RD per OP; OP 11 SHALL go directly to RSP with RSP_ERR=1, no bus activity.
REQ-024 SHALL handle simultaneous push and pop with count unchanged and no entry lost or duplicated.
REQ-025 SHALL in WR drive CYC_O=STB_O=WE_O=1, ADR_O=cmd ADR, DAT_O=cmd DAT; on edge with ACK_I=1 go to RSP.
REQ-026 SHALL in RD drive CYC_O=STB_O=1, WE_O=0; on edge with ACK_I=1 capture DAT_I into rdata and go to RSP.
REQ-027 SHALL in RMW_RD behave as RD but go to RMW_WR, holding CYC_O=STB_O=1 continuously across both phases.
REQ-028 SHALL in RMW_WR write (rdata & ~MSK) | (DAT & MSK); on ACK_I go to RSP.
REQ-029 SHALL drive DAT_O = 8'h00 whenever WE_O=0, and CYC_O=STB_O=WE_O=0 in IDLE and RSP.
REQ-030 SHALL count cycles spent in any bus state without ACK_I, reset the count on each phase change, and on reaching TMO drop CYC_O/STB_O and go to RSP with RSP_ERR=1 (RMW aborted in either phase, no write phase after read timeout).
REQ-031 SHALL in RSP assert RSP_VALID for exactly one cycle, then return to IDLE; RSP_DAT = rdata for read, write data for write, original rdata for RMW, 8'h00 on error.
REQ-032 SHALL give zero-wait latency: command accepted at edge N -> bus state during cycle after N+1 -> RSP_VALID during cycle after N+2 (write/read); RMW adds one cycle.
REQ-033 SHALL ignore ACK_I outside bus states.

Reset
REQ-034 SHALL on RST_I=1 immediately (asynchronously) empty the FIFO, enter IDLE, clear counters, rdata, and command registers, and drive CMD_READY=0, RSP_VALID=0, RSP_DAT=0, RSP_ERR=0, CYC_O=STB_O=WE_O=0, ADR_O=0, DAT_O=0.
REQ-035 SHALL on reset mid-cycle drop CYC_O/STB_O without waiting for ACK_I and emit no response; CMD_READY=1 from the first edge after RST_I deasserts.

Verification
REQ-036 SHALL cover: write ADR=3 DAT=A5 to zero-wait slave -> one cycle CYC/STB/WE=1, DAT_O=A5, then RSP_VALID with RSP_DAT=A5, RSP_ERR=0.
REQ-037 SHALL cover: RMW DAT=0F MSK=0F against slave holding C3 -> read C3, write CF, RSP_DAT=C3, CYC_O high for 2 consecutive cycles.
REQ-038 SHALL cover: read with ACK_I tied 0 -> CYC_O high exactly 16 cycles, RSP_ERR=1, RSP_DAT=00.
REQ-039 SHALL cover: push 5 commands back-to-back with slave stalled -> CMD_READY low after 4th pop-free entry, all 5 complete in order.
REQ-040 SHALL cover: RST_I asserted during RMW_WR -> CYC_O/STB_O low in same cycle, no RSP_VALID, FIFO empty.
REQ-041 SHALL cover: OP=11 -> RSP_ERR=1 pulse, CYC_O never asserted.

Source files
------------

// File: rtl/wb_master08.sv
// Wishbone classic master: command FIFO, read / write / read-modify-write
// sequencing, and a per-phase ACK timeout that aborts the cycle.
module wb_master08 #(
  parameter int DEPTH = 4,
  parameter int TMO   = 16
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_OP,
  input  logic [3:0] CMD_ADR,
  input  logic [7:0] CMD_DAT,
  input  logic [7:0] CMD_MSK,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DAT,
  output logic       RSP_ERR,
  output logic       CYC_O,
  output logic       STB_O,
  output logic       WE_O,
  output logic [3:0] ADR_O,
  output logic [7:0] DAT_O,
  input  logic [7:0] DAT_I,
  input  logic       ACK_I
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TMO + 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  typedef enum logic [2:0] {
    IDLE, WR, RD, RMW_RD, RMW_WR, RSP
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] adr;
    logic [7:0] dat;
    logic [7:0] msk;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          rdy_q;
  logic          push;
  logic          pop;
  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic [7:0]    rdata;
  logic [7:0]    cmd_dat;
  logic [7:0]    cmd_msk;

  // rdy_q keeps CMD_READY low until the first edge after reset
  assign CMD_READY = rdy_q && (count != FULL);
  assign push      = CMD_VALID && CMD_READY;
  assign pop       = (state == IDLE) && (count != '0);
  assign head      = mem[rd_ptr];
  assign tmo_hit   = (tmo_cnt == TMO_LAST);

  always_ff @(posedge CLK_I)
    if (push)
      mem[wr_ptr] <= {CMD_OP, CMD_ADR, CMD_DAT, CMD_MSK};

  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end

  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      rdata     <= '0;
      cmd_dat   <= '0;
      cmd_msk   <= '0;
      RSP_VALID <= 1'b0;
      RSP_DAT   <= '0;
      RSP_ERR   <= 1'b0;
      CYC_O     <= 1'b0;
      STB_O     <= 1'b0;
      WE_O      <= 1'b0;
      ADR_O     <= '0;
      DAT_O     <= '0;
    end else begin
      unique case (state)
        IDLE: if (pop) begin
          cmd_dat <= head.dat;
          cmd_msk <= head.msk;
          tmo_cnt <= '0;
          ADR_O   <= head.adr;
          DAT_O   <= '0;
          WE_O    <= 1'b0;
          unique case (head.op)
            2'b00: begin
              state <= WR;
              CYC_O <= 1'b1;
              STB_O <= 1'b1;
              WE_O  <= 1'b1;
              DAT_O <= head.dat;
            end
            2'b01: begin
              state <= RD;
              CYC_O <= 1'b1;
              STB_O <= 1'b1;
            end
            2'b10: begin
              state <= RMW_RD;
              CYC_O <= 1'b1;
              STB_O <= 1'b1;
            end
            default: begin
              state     <= RSP;
              RSP_VALID <= 1'b1;
              RSP_ERR   <= 1'b1;
              RSP_DAT   <= '0;
            end
          endcase
        end
        WR, RD, RMW_RD, RMW_WR: begin
          if (ACK_I && state == RMW_RD) begin
            // CYC/STB stay high into the write phase
            state   <= RMW_WR;
            tmo_cnt <= '0;
            rdata   <= DAT_I;
            WE_O    <= 1'b1;
            DAT_O   <= (DAT_I & ~cmd_msk) | (cmd_dat & cmd_msk);
          end else if (ACK_I || tmo_hit) begin
            state     <= RSP;
            tmo_cnt   <= '0;
            CYC_O     <= 1'b0;
            STB_O     <= 1'b0;
            WE_O      <= 1'b0;
            DAT_O     <= '0;
            RSP_VALID <= 1'b1;
            RSP_ERR   <= !ACK_I;
            priority case (1'b1)
              !ACK_I:      RSP_DAT <= '0;
              state == WR: RSP_DAT <= cmd_dat;
              state == RD: begin
                RSP_DAT <= DAT_I;
                rdata   <= DAT_I;
              end
              default:     RSP_DAT <= rdata;
            endcase
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        RSP: begin
          state     <= IDLE;
          RSP_VALID <= 1'b0;
          RSP_ERR   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end

endmodule

// File: tb/tb_wb_master08.sv
// Directed bench for wb_master08 with a small combinational-ACK slave.
module tb_wb_master08;

  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic [1:0] CMD_OP = '0;
  logic [3:0] CMD_ADR = '0;
  logic [7:0] CMD_DAT = '0;
  logic [7:0] CMD_MSK = '0;
  logic       RSP_VALID;
  logic [7:0] RSP_DAT;
  logic       RSP_ERR;
  logic       CYC_O;
  logic       STB_O;
  logic       WE_O;
  logic [3:0] ADR_O;
  logic [7:0] DAT_O;
  logic [7:0] DAT_I;
  logic       ACK_I;

  logic [1:0] ack_mode = 2'd1;
  logic [7:0] slv_rdata = 8'h00;

  int n_chk = 0;
  int n_pass = 0;
  int cyc_cnt = 0;
  int rsp_cnt = 0;
  logic [11:0] wr_q[$];

  wb_master08 #(.DEPTH(4), .TMO(16)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_ADR(CMD_ADR),
    .CMD_DAT(CMD_DAT), .CMD_MSK(CMD_MSK),
    .RSP_VALID(RSP_VALID), .RSP_DAT(RSP_DAT), .RSP_ERR(RSP_ERR),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I), .ACK_I(ACK_I)
  );

  always #5 CLK_I = ~CLK_I;

  // mode 0: stalled, 1: zero-wait, 2: acks reads only
  assign ACK_I = CYC_O && STB_O &&
    (ack_mode == 2'd1 || (ack_mode == 2'd2 && !WE_O));
  assign DAT_I = slv_rdata;

  always @(negedge CLK_I) begin
    if (CYC_O) cyc_cnt++;
    if (RSP_VALID) rsp_cnt++;
    if (CYC_O && STB_O && WE_O && ACK_I)
      wr_q.push_back({ADR_O, DAT_O});
  end

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic push(logic [1:0] op, logic [3:0] adr,
                      logic [7:0] dat, logic [7:0] msk);
    int n;
    n = 0;
    CMD_VALID = 1'b1;
    CMD_OP = op;
    CMD_ADR = adr;
    CMD_DAT = dat;
    CMD_MSK = msk;
    while (!CMD_READY && n < 50) begin
      @(posedge CLK_I);
      #1;
      n++;
    end
    if (n == 50) chk("push_tmo", 16'd0, 16'd1);
    @(posedge CLK_I);
    #1;
    CMD_VALID = 1'b0;
  endtask

  task automatic expect_rsp(string tag, int max, logic err, logic [7:0] dat);
    int n;
    n = 0;
    do begin
      @(negedge CLK_I);
      n++;
    end while (!RSP_VALID && n < max);
    if (!RSP_VALID) chk({tag, "_none"}, 16'd0, 16'd1);
    else begin
      chk({tag, "_err"}, 16'(RSP_ERR), 16'(err));
      chk({tag, "_dat"}, 16'(RSP_DAT), 16'(dat));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    int wq;
    repeat (3) @(posedge CLK_I);
    #1;
    chk("rst_ready", 16'(CMD_READY), 16'd0);
    chk("rst_cyc", 16'({CYC_O, STB_O, WE_O}), 16'd0);
    chk("rst_rsp", 16'({RSP_VALID, RSP_ERR, RSP_DAT}), 16'd0);
    chk("rst_adr", 16'(ADR_O), 16'd0);
    chk("rst_dato", 16'(DAT_O), 16'd0);
    RST_I = 1'b0;
    #1;
    chk("ready_pre_edge", 16'(CMD_READY), 16'd0);
    @(posedge CLK_I);
    #1;
    chk("ready_post", 16'(CMD_READY), 16'd1);

    // write, zero-wait
    cyc_cnt = 0;
    wr_q.delete();
    push(2'b00, 4'd3, 8'hA5, 8'h00);
    @(negedge CLK_I);
    chk("wr_idle_cyc", 16'(CYC_O), 16'd0);
    @(negedge CLK_I);
    chk("wr_bus", 16'({CYC_O, STB_O, WE_O}), 16'h7);
    chk("wr_adr", 16'(ADR_O), 16'h3);
    chk("wr_dato", 16'(DAT_O), 16'hA5);
    @(negedge CLK_I);
    chk("wr_rsp", 16'({RSP_VALID, RSP_ERR, RSP_DAT}), 16'h2A5);
    chk("wr_cyc_off", 16'(CYC_O), 16'd0);
    @(negedge CLK_I);
    chk("wr_rsp_pulse", 16'(RSP_VALID), 16'd0);
    chk("wr_cyc_cnt", 16'(cyc_cnt), 16'd1);
    chk("wr_q", 16'(wr_q.size() == 1 ? wr_q[0] : 12'hFFF), 16'h3A5);

    // read, zero-wait
    slv_rdata = 8'h5A;
    push(2'b01, 4'd7, 8'h99, 8'h00);
    @(negedge CLK_I);
    @(negedge CLK_I);
    chk("rd_bus", 16'({CYC_O, STB_O, WE_O}), 16'h6);
    chk("rd_adr", 16'(ADR_O), 16'h7);
    chk("rd_dato", 16'(DAT_O), 16'h00);
    @(negedge CLK_I);
    chk("rd_rsp", 16'({RSP_VALID, RSP_ERR, RSP_DAT}), 16'h25A);

    // read-modify-write against C3
    slv_rdata = 8'hC3;
    cyc_cnt = 0;
    wr_q.delete();
    push(2'b10, 4'd2, 8'h0F, 8'h0F);
    @(negedge CLK_I);
    @(negedge CLK_I);
    chk("rmw_rd", 16'({CYC_O, STB_O, WE_O}), 16'h6);
    @(negedge CLK_I);
    chk("rmw_wr", 16'({CYC_O, STB_O, WE_O}), 16'h7);
    chk("rmw_dato", 16'(DAT_O), 16'hCF);
    @(negedge CLK_I);
    chk("rmw_rsp", 16'({RSP_VALID, RSP_ERR, RSP_DAT}), 16'h2C3);
    @(posedge CLK_I);
    #1;
    chk("rmw_cyc_cnt", 16'(cyc_cnt), 16'd2);
    chk("rmw_wq", 16'(wr_q.size() == 1 ? wr_q[0] : 12'hFFF), 16'h2CF);

    // read timeout
    ack_mode = 2'd0;
    cyc_cnt = 0;
    push(2'b01, 4'd4, 8'h00, 8'h00);
    expect_rsp("tmo_rd", 40, 1'b1, 8'h00);
    @(posedge CLK_I);
    #1;
    chk("tmo_rd_cyc", 16'(cyc_cnt), 16'd16);

    // RMW timeout in read phase: no write phase follows
    cyc_cnt = 0;
    wr_q.delete();
    push(2'b10, 4'd5, 8'hFF, 8'hFF);
    expect_rsp("tmo_rmw", 40, 1'b1, 8'h00);
    @(posedge CLK_I);
    #1;
    chk("tmo_rmw_cyc", 16'(cyc_cnt), 16'd16);
    chk("tmo_rmw_wq", 16'(wr_q.size()), 16'd0);

    // reserved op
    ack_mode = 2'd1;
    cyc_cnt = 0;
    push(2'b11, 4'd1, 8'h12, 8'h34);
    @(negedge CLK_I);
    @(negedge CLK_I);
    chk("op11_rsp", 16'({RSP_VALID, RSP_ERR, RSP_DAT}), 16'h300);
    @(posedge CLK_I);
    #1;
    chk("op11_cyc", 16'(cyc_cnt), 16'd0);

    // five back-to-back writes with a stalled slave
    ack_mode = 2'd0;
    wr_q.delete();
    for (int i = 1; i <= 5; i++)
      push(2'b00, 4'(i), 8'(i * 8'h11), 8'h00);
    chk("full_ready", 16'(CMD_READY), 16'd0);
    ack_mode = 2'd1;
    for (int i = 1; i <= 5; i++)
      expect_rsp($sformatf("b2b%0d", i), 12, 1'b0, 8'(i * 8'h11));
    chk("b2b_wq_n", 16'(wr_q.size()), 16'd5);
    for (int i = 0; i < 5 && i < wr_q.size(); i++)
      chk($sformatf("b2b_wq%0d", i), 16'(wr_q[i]),
          16'({4'(i + 1), 8'((i + 1) * 8'h11)}));

    // reset during RMW write phase, one more command queued
    ack_mode = 2'd2;
    slv_rdata = 8'h3C;
    push(2'b10, 4'd6, 8'hF0, 8'h0F);
    push(2'b00, 4'd9, 8'h77, 8'h00);
    @(negedge CLK_I);
    @(negedge CLK_I);
    chk("rst_mid_we", 16'({CYC_O, WE_O}), 16'h3);
    rc = rsp_cnt;
    wq = wr_q.size();
    RST_I = 1'b1;
    #1;
    chk("rst_mid_bus", 16'({CYC_O, STB_O, WE_O}), 16'd0);
    chk("rst_mid_ready", 16'(CMD_READY), 16'd0);
    chk("rst_mid_dato", 16'(DAT_O), 16'd0);
    @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
    cyc_cnt = 0;
    @(posedge CLK_I);
    #1;
    chk("rst_mid_ready1", 16'(CMD_READY), 16'd1);
    repeat (10) @(posedge CLK_I);
    #1;
    chk("rst_mid_nocyc", 16'(cyc_cnt), 16'd0);
    chk("rst_mid_norsp", 16'(rsp_cnt - rc), 16'd0);
    chk("rst_mid_nowr", 16'(wr_q.size() - wq), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
